logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares one 32-bit bitwise logic unit (AND/OR/XOR) between N_REQ requesters, e.g. the
//  core ALU port, a CSR read-modify-write path and a debug port. Uses fair round-robin
//  arbitration with a valid/ready handshake on each request port and one registered
//  response channel. The response carries the winner's ID. Sits between the requesters
//  and the shared logic datapath; latency is 1 cycle from accept to response.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8); ID width IDW = $clog2(N_REQ)
//  DATA_W  32  operand/result width
// PORTS
//  i_clk          in   1             clock; all state updates on rising edge
//  i_reset        in   1             asynchronous, active-high reset
//  i_req_valid    in   N_REQ         request valid, one bit per requester
//  i_req_op       in   2*N_REQ       op per requester, [2i+1:2i]; 00 AND, 01 OR, 10 XOR, 11 illegal
//  i_req_a        in   DATA_W*N_REQ  operand A per requester, slice i
//  i_req_b        in   DATA_W*N_REQ  operand B per requester, slice i
//  o_req_ready    out  N_REQ         accept strobe, one-hot or zero
//  o_rsp_valid    out  1             response register holds a result
//  i_rsp_ready    in   1             consumer takes the response this cycle
//  o_rsp_id       out  IDW           index of the requester that owns the response
//  o_rsp_result   out  DATA_W        result of the op
//  o_rsp_err      out  1             op was 11; o_rsp_result is 0
//  o_grant_cnt    out  16            saturating count of accepted requests (perf/debug)
// BEHAVIOUR
//  Reset (async, any time, including mid-transfer):
//   o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_rsp_err=0, o_grant_cnt=0, rr pointer=0.
//   An in-flight response is discarded.
//  accept = i_reset==0 && (!o_rsp_valid || i_rsp_ready). The output register is free or
//   draining this cycle, so back-to-back transfers run at 1/cycle.
//  Grant is combinational: first i with i_req_valid[i]=1, searching ptr, ptr+1, ... wrapping
//   at N_REQ-1 to 0. o_req_ready[g]=accept && any_valid. All other ready bits are 0.
//   Ready may depend on valid. Valid must not depend on ready.
//  On accept of requester g, at the next edge:
//   - o_rsp_valid=1, o_rsp_id=g
//   - o_rsp_result=op(a_g,b_g); op 11 gives result 0 and o_rsp_err=1
//   - ptr=(g+1) mod N_REQ
//   - o_grant_cnt+=1, saturating at 16'hFFFF
//  No accept:
//   - if i_rsp_ready=1, o_rsp_valid goes to 0
//   - ptr and all other state hold; the response payload holds while o_rsp_valid=1
//  Response FSM (2 states):
//   - EMPTY -(grant)-> FULL
//   - FULL -(rsp_ready && grant)-> FULL
//   - FULL -(rsp_ready && !grant)-> EMPTY
//   - FULL -(!rsp_ready)-> FULL (stall, all o_req_ready=0)
//  Requester protocol: hold valid and payload stable until ready. Dropping valid before
//   ready is allowed and is treated as withdrawn. It is never granted afterwards.
//  Fairness: a continuously valid requester is accepted within N_REQ accepts.
//  A single requester gets full throughput.
//  Simultaneous rsp_ready and new grant in the same cycle: the old response retires and
//   the new one loads. No bubble, no loss.
// STRUCTURE
//  Shared package logic_pkg:
//   - typedef enum logic [1:0] {LOP_AND=2'b00, LOP_OR=2'b01, LOP_XOR=2'b10} logic_op_e
//   - function logic_eval(op,a,b) returning 0 for 2'b11
//   - localparam GRANT_CNT_W=16
//  Sub-module rr_arbiter #(N): i_req[N], i_ptr -> o_grant one-hot, o_grant_idx, o_any.
//   Combinational and reusable. Pointer and counter registers stay in the top.
// TESTING
//  1 Reset: assert i_reset mid-stall with o_rsp_valid=1 ->
//    outputs 0 immediately (async), ptr=0, after release first grant goes to req0.
//  2 Single req: req1 valid, op=00, a=F0F0_F0F0, b=FF00_FF00, rsp_ready=1 ->
//    ready[1] same cycle, next cycle rsp_valid=1, id=1, result=F000_F000, err=0.
//  3 Round robin: all 4 valid every cycle, op=10, rsp_ready=1 ->
//    grant order 0,1,2,3,0; one response per cycle; o_grant_cnt=5 after 5 cycles.
//  4 Backpressure: rsp_ready=0 for 3 cycles with reqs pending ->
//    o_req_ready=0, response stable (id/result unchanged), ptr frozen;
//    rsp_ready=1 -> retire and new grant in the same cycle.
//  5 Illegal op: req2 op=11, a=b=FFFF_FFFF -> result=0, err=1, id=2.
//    Also cover withdraw: req3 valid 1 cycle during a stall, then 0 -> never responded.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared definitions for the arbitrated bitwise logic unit: op encodings,
// response-channel state and the per-bit evaluation helper.
package logic_pkg;

  localparam int GRANT_CNT_W = 16;

  typedef enum logic [1:0] {
    LOP_AND = 2'b00,
    LOP_OR  = 2'b01,
    LOP_XOR = 2'b10
  } logic_op_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Bit-level evaluation keeps the helper independent of the datapath width;
  // the caller applies it across every bit. Encoding 2'b11 yields 0.
  function automatic logic logic_eval(input logic [1:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      LOP_AND: r = a & b;
      LOP_OR:  r = a | b;
      LOP_XOR: r = a ^ b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping from N-1 back to 0. Holds no state.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_grant_idx,
  output logic           o_any
);

  always_comb begin
    int  idx;
    logic found;
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(i_ptr) + k) % N;
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_idx  = IDW'(idx);
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise AND/OR/XOR unit between N_REQ requesters,
// with a single registered response channel (1-cycle accept-to-response latency).
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int IDW    = $clog2(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [2*N_REQ-1:0]        i_req_op,
  input  logic [DATA_W*N_REQ-1:0]   i_req_a,
  input  logic [DATA_W*N_REQ-1:0]   i_req_b,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [IDW-1:0]            o_rsp_id,
  output logic [DATA_W-1:0]         o_rsp_result,
  output logic                      o_rsp_err,
  output logic [GRANT_CNT_W-1:0]    o_grant_cnt
);

  // Handshake: a request transfers on a cycle where i_req_valid[i] && o_req_ready[i];
  // the response transfers where o_rsp_valid && i_rsp_ready. Ready may look at valid,
  // valid never looks at ready; a valid dropped before ready counts as withdrawn.

  rsp_state_e            rsp_state, rsp_state_d;
  logic [IDW-1:0]        ptr_q;
  logic [N_REQ-1:0]      grant_vec;
  logic [IDW-1:0]        grant_idx;
  logic                  any_valid;
  logic                  accept;
  logic                  grant;
  logic [1:0]            op_g;
  logic [DATA_W-1:0]     a_g, b_g, result_d;

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_rr (
    .i_req       (i_req_valid),
    .i_ptr       (ptr_q),
    .o_grant     (grant_vec),
    .o_grant_idx (grant_idx),
    .o_any       (any_valid)
  );

  // Output register is free, or is being drained this cycle.
  assign o_rsp_valid = (rsp_state == RSP_FULL);
  assign accept      = !i_reset && (!o_rsp_valid || i_rsp_ready);
  assign grant       = accept && any_valid;
  assign o_req_ready = grant ? grant_vec : '0;

  assign op_g = i_req_op[2*grant_idx +: 2];
  assign a_g  = i_req_a[DATA_W*grant_idx +: DATA_W];
  assign b_g  = i_req_b[DATA_W*grant_idx +: DATA_W];

  always_comb begin
    result_d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      result_d[i] = logic_eval(op_g, a_g[i], b_g[i]);
    end
  end

  always_comb begin
    rsp_state_d = rsp_state;
    case (rsp_state)
      RSP_EMPTY: if (grant) rsp_state_d = RSP_FULL;
      RSP_FULL:  if (i_rsp_ready && !grant) rsp_state_d = RSP_EMPTY;
      default:   rsp_state_d = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rsp_state <= RSP_EMPTY;
    end else begin
      rsp_state <= rsp_state_d;
    end
  end

  // Payload only loads on a grant, so it stays put during a stall.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_q        <= '0;
      o_rsp_id     <= '0;
      o_rsp_result <= '0;
      o_rsp_err    <= 1'b0;
      o_grant_cnt  <= '0;
    end else if (grant) begin
      ptr_q        <= (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + IDW'(1);
      o_rsp_id     <= grant_idx;
      o_rsp_result <= result_d;
      o_rsp_err    <= (op_g == 2'b11);
      if (o_grant_cnt != '1) o_grant_cnt <= o_grant_cnt + GRANT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: driver tasks push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_logic_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;
  localparam int EW = 1 + IW + W;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_op;
  logic [W*N-1:0]  req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_result;
  logic [15:0]     grant_cnt;

  logic [EW-1:0]   exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;

  logic_unit_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .i_req_op     (req_op),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_result (rsp_result),
    .o_rsp_err    (rsp_err),
    .o_grant_cnt  (grant_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_valid[i]       = 1'b1;
    req_op[2*i +: 2]   = op;
    req_a[W*i +: W]    = a;
    req_b[W*i +: W]    = b;
  endtask

  task automatic step(input logic [N-1:0] exp_rdy, input logic push, input logic [EW-1:0] exp);
    @(negedge clk);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got id=%0d res=%h err=%b, expected none", rsp_id,
                 rsp_result, rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp", 64'({rsp_err, rsp_id, rsp_result}), 64'(e));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_grant_cnt", 64'(grant_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single requester, AND
    rsp_ready = 1'b1;
    set_req(1, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step(4'b0010, 1'b1, {1'b0, 2'd1, 32'hF000_F000});
    req_valid = '0;
    step(4'b0000, 1'b0, '0);

    // illegal op from req2 (ptr now 2)
    set_req(2, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(4'b0100, 1'b1, {1'b1, 2'd2, 32'h0});
    // withdraw: req3 valid for one stalled cycle only
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(3, 2'b00, 32'h1111_1111, 32'h2222_2222);
    step(4'b0000, 1'b0, '0);
    check("stall_err_held", 64'({rsp_valid, rsp_err, rsp_id}), 64'({1'b1, 1'b1, 2'd2}));
    req_valid = '0;
    step(4'b0000, 1'b0, '0);
    rsp_ready = 1'b1;
    step(4'b0000, 1'b0, '0);

    // backpressure (ptr = 3, so req0 wins over req1)
    set_req(0, 2'b01, 32'h1234_0000, 32'h0000_5678);
    set_req(1, 2'b01, 32'hA0A0_A0A0, 32'h0505_0505);
    step(4'b0001, 1'b1, {1'b0, 2'd0, 32'h1234_5678});
    req_valid[0] = 1'b0;
    set_req(2, 2'b01, 32'hFFFF_0000, 32'h0000_0001);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(4'b0000, 1'b0, '0);
      check("stall_held", 64'({rsp_valid, rsp_id, rsp_result}),
            64'({1'b1, 2'd0, 32'h1234_5678}));
    end
    rsp_ready = 1'b1;
    step(4'b0010, 1'b1, {1'b0, 2'd1, 32'hA5A5_A5A5});
    req_valid[1] = 1'b0;
    step(4'b0100, 1'b1, {1'b0, 2'd2, 32'hFFFF_0001});
    req_valid = '0;
    step(4'b0000, 1'b0, '0);
    check("grant_cnt_5a", 64'(grant_cnt), 64'd5);

    // async reset during a stall with a held response
    rsp_ready = 1'b0;
    set_req(0, 2'b10, 32'h0000_0001, 32'h0000_0003);
    step(4'b0001, 1'b1, {1'b0, 2'd0, 32'h0000_0002});
    step(4'b0000, 1'b0, '0);
    check("pre_reset_valid", 64'(rsp_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_payload", 64'({rsp_err, rsp_id, rsp_result}), 64'd0);
    check("async_grant_cnt", 64'(grant_cnt), 64'd0);
    check("async_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // round robin, all valid, XOR
    rsp_ready = 1'b1;
    set_req(0, 2'b10, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    set_req(1, 2'b10, 32'h1234_5678, 32'h1234_5678);
    set_req(2, 2'b10, 32'hAAAA_AAAA, 32'h5555_5555);
    set_req(3, 2'b10, 32'h8000_0000, 32'h0000_0001);
    step(4'b0001, 1'b1, {1'b0, 2'd0, 32'hF0F0_F0F0});
    step(4'b0010, 1'b1, {1'b0, 2'd1, 32'h0000_0000});
    step(4'b0100, 1'b1, {1'b0, 2'd2, 32'hFFFF_FFFF});
    step(4'b1000, 1'b1, {1'b0, 2'd3, 32'h8000_0001});
    step(4'b0001, 1'b1, {1'b0, 2'd0, 32'hF0F0_F0F0});
    req_valid = '0;
    step(4'b0000, 1'b0, '0);
    check("grant_cnt_5b", 64'(grant_cnt), 64'd5);
    check("drained_valid", 64'(rsp_valid), 64'd0);
    step(4'b0000, 1'b0, '0);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
